mouse_tracker: RTL and testbench

Assembles 3-byte PS/2 mouse packets from the PS/2 byte receiver and keeps an absolute cursor position and left-button state clamped to the 800x600 playfield. It is the producing end of the mouse position path: its `xpos_out`/`ypos_out`/`left_out` feed the position-register stage, which re-times them into the `pclk` game/draw pipeline.

---
 rtl/mouse_tracker_pkg.sv | 41 ++++
 rtl/mouse_axis_clamp.sv | 32 +++
 rtl/mouse_tracker.sv | 167 ++++++++++++++++
 tb/tb_mouse_tracker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_tracker_pkg.sv
// Purpose: shared screen geometry, PS/2 packet field positions and mouse-path defaults.
// Latency: n/a (constants, types and a helper only).
// Backpressure: n/a.
package mouse_tracker_pkg;

  localparam int SCREEN_W    = 800;
  localparam int SCREEN_H    = 600;
  localparam int SCREEN_XMAX = SCREEN_W - 1;
  localparam int SCREEN_YMAX = SCREEN_H - 1;
  localparam int POS_X_INIT  = SCREEN_W / 2;
  localparam int POS_Y_INIT  = SCREEN_H / 2;

  // 1 ms of idle at a 40 MHz pclk.
  localparam int PS2_TIMEOUT_40MHZ = 40000;

  // Bit positions inside PS/2 packet byte 0.
  localparam int B0_LEFT   = 0;
  localparam int B0_RIGHT  = 1;
  localparam int B0_MIDDLE = 2;
  localparam int B0_SYNC   = 3;
  localparam int B0_XSIGN  = 4;
  localparam int B0_YSIGN  = 5;
  localparam int B0_XOVF   = 6;
  localparam int B0_YOVF   = 7;

  // Fields of byte 0 that the tracker actually consumes.
  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic left;
  } ps2_hdr_t;

  // 9-bit {sign, byte} delta widened to 10 bits so the y axis can be negated
  // without the -256 case wrapping.
  function automatic logic [9:0] ps2_delta(input logic sign, input logic [7:0] mag);
    return {sign, sign, mag};
  endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// Purpose: one axis of the cursor: position + signed delta, clamped to [0, MAX].
// Latency: combinational.
// Backpressure: none.
// Ports: pos_in (current 11-bit position), delta_in (10-bit two's complement delta),
//        ovf_in (axis overflow: delta treated as 0), pos_out (clamped new position).
module mouse_axis_clamp
  import mouse_tracker_pkg::*;
#(
  parameter int MAX = SCREEN_XMAX
) (
  input  logic [10:0] pos_in,
  input  logic [9:0]  delta_in,
  input  logic        ovf_in,
  output logic [10:0] pos_out
);

  logic [12:0] delta_ext;
  logic [12:0] sum;

  always_comb begin
    delta_ext = ovf_in ? 13'd0 : {{3{delta_in[9]}}, delta_in};
    sum       = {2'b00, pos_in} + delta_ext;
    if (sum[12]) begin
      pos_out = '0;                     // went negative
    end else if (sum[11:0] > 12'(MAX)) begin
      pos_out = 11'(MAX);
    end else begin
      pos_out = sum[10:0];
    end
  end

endmodule

// File: rtl/mouse_tracker.sv
// Purpose: assemble 3-byte PS/2 mouse packets into a clamped absolute cursor + left button.
// Latency: outputs and packet_done update one pclk after byte 2 is sampled.
// Backpressure: none; accepts one byte per cycle, bytes arriving during APPLY start the next packet.
// Ports: pclk, rst (async, active-high); rx_data/rx_valid byte strobe from the PS/2 receiver;
//        xpos_out/ypos_out (0..XMAX / 0..YMAX, y down-positive), left_out, packet_done pulse.
module mouse_tracker
  import mouse_tracker_pkg::*;
#(
  parameter int XMAX    = SCREEN_XMAX,
  parameter int YMAX    = SCREEN_YMAX,
  parameter int X_INIT  = POS_X_INIT,
  parameter int Y_INIT  = POS_Y_INIT,
  parameter int TIMEOUT = PS2_TIMEOUT_40MHZ
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [10:0] xpos_out,
  output logic [10:0] ypos_out,
  output logic        left_out,
  output logic        packet_done
);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    APPLY   = 2'd3
  } state_e;

  // The counter holds the number of idle edges since the last byte, so it
  // reads TIMEOUT-1 on the edge that lands exactly TIMEOUT cycles later.
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  ps2_hdr_t    hdr_q, hdr_d;
  logic [7:0]  dx_q, dx_d;
  logic [7:0]  dy_q, dy_d;
  logic [10:0] xpos_q, xpos_d;
  logic [10:0] ypos_q, ypos_d;
  logic        left_q, left_d;
  logic        done_q, done_d;

  logic        timed_out;
  logic        start_pkt;
  logic        take_b0;
  logic [9:0]  dx_ext;
  logic [9:0]  dy_neg;
  logic [10:0] x_clamped;
  logic [10:0] y_clamped;

  assign timed_out = (idle_cnt_q >= IDLE_LAST);
  assign start_pkt = rx_valid && rx_data[B0_SYNC];
  // APPLY treats an incoming byte exactly like WAIT_B0 does.
  assign take_b0   = start_pkt && ((state_q == WAIT_B0) || (state_q == APPLY));

  // ---------------- state register ----------------
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_B0;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_B0: if (start_pkt) state_d = WAIT_B1;
      WAIT_B1: begin
        if (rx_valid)       state_d = WAIT_B2;
        else if (timed_out) state_d = WAIT_B0;
      end
      WAIT_B2: begin
        if (rx_valid)       state_d = APPLY;
        else if (timed_out) state_d = WAIT_B0;
      end
      APPLY:   state_d = start_pkt ? WAIT_B1 : WAIT_B0;
      default: state_d = WAIT_B0;
    endcase
  end

  // ---------------- datapath / output logic ----------------
  assign dx_ext = ps2_delta(hdr_q.x_sign, dx_q);
  // PS/2 y is up-positive, screen y is down-positive.
  assign dy_neg = 10'd0 - ps2_delta(hdr_q.y_sign, dy_q);

  mouse_axis_clamp #(.MAX(XMAX)) u_clamp_x (
    .pos_in   (xpos_q),
    .delta_in (dx_ext),
    .ovf_in   (hdr_q.x_ovf),
    .pos_out  (x_clamped)
  );

  mouse_axis_clamp #(.MAX(YMAX)) u_clamp_y (
    .pos_in   (ypos_q),
    .delta_in (dy_neg),
    .ovf_in   (hdr_q.y_ovf),
    .pos_out  (y_clamped)
  );

  always_comb begin
    hdr_d  = hdr_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    xpos_d = xpos_q;
    ypos_d = ypos_q;
    left_d = left_q;
    done_d = 1'b0;

    if (rx_valid) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == 16'hFFFF) begin
      idle_cnt_d = idle_cnt_q;
    end else begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end

    if (take_b0) begin
      hdr_d.left   = rx_data[B0_LEFT];
      hdr_d.x_sign = rx_data[B0_XSIGN];
      hdr_d.y_sign = rx_data[B0_YSIGN];
      hdr_d.x_ovf  = rx_data[B0_XOVF];
      hdr_d.y_ovf  = rx_data[B0_YOVF];
    end
    if ((state_q == WAIT_B1) && rx_valid) dx_d = rx_data;
    if ((state_q == WAIT_B2) && rx_valid) dy_d = rx_data;

    if (state_q == APPLY) begin
      xpos_d = x_clamped;
      ypos_d = y_clamped;
      left_d = hdr_q.left;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
      hdr_q      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      xpos_q     <= 11'(X_INIT);
      ypos_q     <= 11'(Y_INIT);
      left_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      hdr_q      <= hdr_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      left_q     <= left_d;
      done_q     <= done_d;
    end
  end

  assign xpos_out    = xpos_q;
  assign ypos_out    = ypos_q;
  assign left_out    = left_q;
  assign packet_done = done_q;

endmodule

// File: tb/tb_mouse_tracker.sv
// Purpose: self-checking bench for mouse_tracker against a byte-stream reference model.
// Latency: model applies a packet one edge after its third byte.
// Backpressure: n/a (bench drives at most one byte per cycle).
module tb_mouse_tracker;
  import mouse_tracker_pkg::*;

  localparam int TO = PS2_TIMEOUT_40MHZ;

  logic        pclk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [10:0] xpos_out;
  logic [10:0] ypos_out;
  logic        left_out;
  logic        packet_done;

  always #5 pclk = ~pclk;

  mouse_tracker dut (
    .pclk        (pclk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .xpos_out    (xpos_out),
    .ypos_out    (ypos_out),
    .left_out    (left_out),
    .packet_done (packet_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;
  int pulses   = 0;

  // Reference model: cursor state plus the bytes of the packet in progress.
  int         mx, my;
  logic       mleft;
  logic [7:0] part[$];
  int         last_byte_edge;
  bit         pend;
  int         pend_edge, pend_x, pend_y;
  logic       pend_left;
  logic       exp_done;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_n);
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int delta9(input logic s, input logic [7:0] b);
    return s ? int'(b) - 256 : int'(b);
  endfunction

  task automatic model_reset();
    mx = POS_X_INIT; my = POS_Y_INIT; mleft = 1'b0;
    part.delete(); pend = 0; exp_done = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] d);
    logic [7:0] b0;
    int dx, dy;
    if (part.size() != 0 && (edge_n - last_byte_edge - 1) >= TO) part.delete();
    last_byte_edge = edge_n;
    if (part.size() == 0 && !d[3]) return;
    part.push_back(d);
    if (part.size() == 3) begin
      b0 = part[0];
      dx = b0[6] ? 0 : delta9(b0[4], part[1]);
      dy = b0[7] ? 0 : delta9(b0[5], part[2]);
      pend_x    = clampi(mx + dx, SCREEN_XMAX);
      pend_y    = clampi(my - dy, SCREEN_YMAX);
      pend_left = b0[0];
      pend      = 1;
      pend_edge = edge_n + 1;
      part.delete();
    end
  endtask

  // One clock: drive inputs, advance model on the edge, check outputs after it.
  task automatic tick(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge pclk);
    edge_n++;
    if (v) model_byte(d);
    exp_done = 1'b0;
    if (pend && edge_n == pend_edge) begin
      mx = pend_x; my = pend_y; mleft = pend_left; pend = 0; exp_done = 1'b1;
    end
    #1;
    if (packet_done) pulses++;
    chk("xpos", int'(xpos_out), mx);
    chk("ypos", int'(ypos_out), my);
    chk("left", int'(left_out), int'(mleft));
    chk("packet_done", int'(packet_done), int'(exp_done));
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'($urandom));
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    tick(1'b1, b0); tick(1'b1, b1); tick(1'b1, b2);
    idle(2);
  endtask

  task automatic apply_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_x", int'(xpos_out), POS_X_INIT);
    chk("rst_y", int'(ypos_out), POS_Y_INIT);
    chk("rst_left", int'(left_out), 0);
    chk("rst_done", int'(packet_done), 0);
    @(posedge pclk);
    edge_n++;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    last_byte_edge = 0;
    model_reset();
    #1;
    apply_reset();
    idle(2);

    // Basic packet and pulse timing.
    tick(1'b1, 8'h09); tick(1'b1, 8'h0A); tick(1'b1, 8'h05);
    chk("pd_at_b2", int'(packet_done), 0);
    tick(1'b0, 8'h00);
    chk("pd_pulse", int'(packet_done), 1);
    tick(1'b0, 8'h00);
    chk("pd_clear", int'(packet_done), 0);
    chk("p1_x", int'(xpos_out), 410);
    chk("p1_y", int'(ypos_out), 295);
    chk("p1_left", int'(left_out), 1);

    // Negative deltas.
    apply_reset();
    send_pkt(8'h38, 8'hF6, 8'hFB);
    chk("neg_x", int'(xpos_out), 390);
    chk("neg_y", int'(ypos_out), 305);
    chk("neg_left", int'(left_out), 0);

    // Clamp at XMAX, then X overflow.
    apply_reset();
    repeat (3) send_pkt(8'h08, 8'h7F, 8'h00);
    send_pkt(8'h08, 8'h0E, 8'h00);
    chk("x_795", int'(xpos_out), 795);
    send_pkt(8'h08, 8'h14, 8'h00);
    chk("x_clamp_hi", int'(xpos_out), 799);
    send_pkt(8'h48, 8'h7F, 8'h01);
    chk("xovf_x", int'(xpos_out), 799);
    chk("xovf_y", int'(ypos_out), 299);

    // Clamp at 0 on y.
    send_pkt(8'h08, 8'h00, 8'h7F);
    send_pkt(8'h08, 8'h00, 8'h7F);
    send_pkt(8'h08, 8'h00, 8'h2B);
    chk("y_2", int'(ypos_out), 2);
    send_pkt(8'h08, 8'h00, 8'h0A);
    chk("y_clamp_lo", int'(ypos_out), 0);

    // Resync on a leading byte without bit3.
    apply_reset();
    tick(1'b1, 8'h00); tick(1'b1, 8'h09); tick(1'b1, 8'h01); tick(1'b1, 8'h01);
    idle(2);
    chk("resync_x", int'(xpos_out), 401);
    chk("resync_y", int'(ypos_out), 299);

    // Reset in the middle of a packet.
    tick(1'b1, 8'h08); tick(1'b1, 8'h05);
    apply_reset();
    send_pkt(8'h09, 8'h0A, 8'h05);
    chk("post_rst_x", int'(xpos_out), 410);
    chk("post_rst_y", int'(ypos_out), 295);

    // Timeout: a full TIMEOUT gap discards the partial packet.
    pulses = 0;
    tick(1'b1, 8'h08);
    idle(TO);
    tick(1'b1, 8'h01);
    idle(3);
    chk("to_pulses", pulses, 0);
    chk("to_x", int'(xpos_out), 410);
    send_pkt(8'h08, 8'h01, 8'h01);
    chk("to_after_x", int'(xpos_out), 411);
    chk("to_after_y", int'(ypos_out), 294);

    // A shorter gap keeps the packet.
    tick(1'b1, 8'h08); idle(1000); tick(1'b1, 8'h05); idle(500); tick(1'b1, 8'h00);
    idle(2);
    chk("gap_x", int'(xpos_out), 416);

    // Back-to-back packets, byte 0 of the second lands in APPLY.
    pulses = 0;
    tick(1'b1, 8'h08); tick(1'b1, 8'h03); tick(1'b1, 8'h02);
    tick(1'b1, 8'h09); tick(1'b1, 8'h04); tick(1'b1, 8'h01);
    idle(3);
    chk("b2b_pulses", pulses, 2);
    chk("b2b_x", int'(xpos_out), 423);
    chk("b2b_y", int'(ypos_out), 291);

    // Randomized stream checked cycle by cycle against the model.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] b[3];
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(0, 2));
        tick(1'b1, 8'($urandom) & 8'hF7);
      end
      b[0] = 8'($urandom) | 8'h08;
      b[1] = 8'($urandom);
      b[2] = 8'($urandom);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        tick(1'b1, b[k]);
      end
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
